// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports (A = processor,
// B = loader/debug) plus the Memory_Unit side.
// slave  : arbiter view (drives acks, read data and memory controls)
// master : environment view (drives requests and memory read data)
interface mem_port_arbiter_if #(
  parameter int word_size = 8
);
  // Port A
  logic                 req_a;
  logic                 we_a;
  logic [word_size-1:0] addr_a;
  logic [word_size-1:0] wdata_a;
  logic                 ack_a;
  logic [word_size-1:0] rdata_a;
  // Port B
  logic                 req_b;
  logic                 we_b;
  logic [word_size-1:0] addr_b;
  logic [word_size-1:0] wdata_b;
  logic                 ack_b;
  logic [word_size-1:0] rdata_b;
  // Shared status
  logic                 err;
  // Memory_Unit side
  logic [word_size-1:0] mem_addr;
  logic [word_size-1:0] mem_wdata;
  logic                 mem_write;
  logic [word_size-1:0] mem_rdata;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    output ack_a, rdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output ack_b, rdata_b,
    output err,
    output mem_addr, mem_wdata, mem_write,
    input  mem_rdata
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    input  ack_a, rdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  ack_b, rdata_b,
    input  err,
    input  mem_addr, mem_wdata, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port Memory_Unit between the processor
// (port A) and a loader/debug port (port B). Round-robin between the two,
// one transaction at a time: IDLE (grant) -> ACCESS (memory cycle) -> RESP (ack).
// Optional feature: define ADDR_PROTECT_EN to suppress port A writes into
// [PROT_LO, PROT_HI]; such a transaction still completes, with err raised on ack.
module mem_port_arbiter #(
  parameter int word_size = 8
`ifdef ADDR_PROTECT_EN
  ,
  parameter logic [word_size-1:0] PROT_LO = 8'hF0,
  parameter logic [word_size-1:0] PROT_HI = 8'hFF
`endif
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic       {PORT_A, PORT_B}              port_t;

  state_t               r_state;
  state_t               w_next_state;
  port_t                r_owner;
  port_t                r_last;
  logic                 r_we;
  logic [word_size-1:0] r_addr;
  logic [word_size-1:0] r_wdata;
  logic [word_size-1:0] r_rdata_a;
  logic [word_size-1:0] r_rdata_b;

  logic                 w_grant;
  port_t                w_grant_port;
  logic                 w_blocked;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state and grant decision; round-robin favours the port that was not last served.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_port = PORT_A;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_a && bus.req_b) begin
          w_grant      = 1'b1;
          w_grant_port = (r_last == PORT_A) ? PORT_B : PORT_A;
        end else if (bus.req_a) begin
          w_grant      = 1'b1;
          w_grant_port = PORT_A;
        end else if (bus.req_b) begin
          w_grant      = 1'b1;
          w_grant_port = PORT_B;
        end
        if (w_grant) w_next_state = ST_ACCESS;
      end
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Transaction latch at grant; read capture and fairness update at the end of ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= PORT_B;
      r_last    <= PORT_B;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_port;
        if (w_grant_port == PORT_A) begin
          r_we    <= bus.we_a;
          r_addr  <= bus.addr_a;
          r_wdata <= bus.wdata_a;
        end else begin
          r_we    <= bus.we_b;
          r_addr  <= bus.addr_b;
          r_wdata <= bus.wdata_b;
        end
      end
      if (r_state == ST_ACCESS) begin
        r_last <= r_owner;
        if (!r_we) begin
          if (r_owner == PORT_A) r_rdata_a <= bus.mem_rdata;
          else                   r_rdata_b <= bus.mem_rdata;
        end
      end
    end
  end

  // Write protection applies only to port A writes inside the protected window.
`ifdef ADDR_PROTECT_EN
  assign w_blocked = (r_owner == PORT_A) && r_we &&
                     (r_addr >= PROT_LO) && (r_addr <= PROT_HI);
`else
  assign w_blocked = 1'b0;
`endif

  // Outputs decode straight from the state register, so reset clears them at once.
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_write = (r_state == ST_ACCESS) && r_we && !w_blocked;
  assign bus.ack_a     = (r_state == ST_RESP) && (r_owner == PORT_A);
  assign bus.ack_b     = (r_state == ST_RESP) && (r_owner == PORT_B);
  assign bus.err       = (r_state == ST_RESP) && w_blocked;
  assign bus.rdata_a   = r_rdata_a;
  assign bus.rdata_b   = r_rdata_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural Memory_Unit model
// (combinational read, write on the rising edge).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if #(.word_size(8)) bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory_Unit model with a bench-side preload port.
  logic [7:0] mem [256];
  logic       pre_we   = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we)             mem[pre_addr] <= pre_data;
    else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // One complete transaction on port A or B; returns read data, err, number of
  // cycles with mem_write high and the number of edges from request to ack.
  task automatic run_txn(input logic port_b, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, output logic [7:0] rd, output logic er,
                         output int wr_cycles, output int lat);
    logic got;
    got = 1'b0; rd = '0; er = 1'b0; wr_cycles = 0; lat = 0;
    @(negedge clk);
    if (port_b) begin
      bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata; bus.req_b = 1'b1;
    end else begin
      bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata; bus.req_a = 1'b1;
    end
    while (!got && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.mem_write) wr_cycles++;
      if (port_b ? bus.ack_b : bus.ack_a) begin
        got = 1'b1;
        rd  = port_b ? bus.rdata_b : bus.rdata_a;
        er  = bus.err;
      end
    end
    check("txn_done", {31'd0, got}, 32'd1);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
  endtask

  logic [7:0] b2b_addr [3] = '{8'h80, 8'h81, 8'h80};
  logic [7:0] b2b_exp  [3] = '{8'h03, 8'h77, 8'h03};
  logic [7:0] rd;
  logic       er;
  int         wr, lat;

  initial begin
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl",  {28'd0, bus.ack_a, bus.ack_b, bus.err, bus.mem_write}, 32'd0);
    check("rst_mem",   {16'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
    check("rst_rdata", {16'd0, bus.rdata_a, bus.rdata_b}, 32'd0);
    preload(8'h80, 8'h03);
    preload(8'h81, 8'h77);
    preload(8'hF4, 8'h22);
    preload(8'h90, 8'h44);
    rst = 1'b1;

    // Port A read, cycle by cycle
    @(negedge clk);
    bus.we_a = 1'b0; bus.addr_a = 8'h80; bus.req_a = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rd_a_access_ack", {31'd0, bus.ack_a}, 32'd0);
    check("rd_a_mem_addr", {24'd0, bus.mem_addr}, 32'h80);
    @(posedge clk); @(negedge clk);
    check("rd_a_ack", {31'd0, bus.ack_a}, 32'd1);
    check("rd_a_rdata", {24'd0, bus.rdata_a}, 32'h03);
    bus.req_a = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rd_a_ack_pulse", {31'd0, bus.ack_a}, 32'd0);

    // Port B write then port A read of the same address
    run_txn(1'b1, 1'b1, 8'h82, 8'h5A, rd, er, wr, lat);
    check("wr_b_write_cycles", wr, 1);
    check("wr_b_latency", lat, 2);
    check("wr_b_err", {31'd0, er}, 32'd0);
    check("wr_b_mem", {24'd0, mem[8'h82]}, 32'h5A);
    run_txn(1'b0, 1'b0, 8'h82, 8'h00, rd, er, wr, lat);
    check("rd_a_after_b", {24'd0, rd}, 32'h5A);
    check("rd_a_no_write", wr, 0);

    // Back-to-back reads with req_a held across acks
    begin
      int idx = 0;
      int last_c = 0;
      @(negedge clk);
      bus.we_a = 1'b0; bus.addr_a = b2b_addr[0]; bus.req_a = 1'b1;
      for (int c = 1; c <= 30 && idx < 3; c++) begin
        @(posedge clk); @(negedge clk);
        if (bus.ack_a) begin
          check("b2b_rdata", {24'd0, bus.rdata_a}, {24'd0, b2b_exp[idx]});
          if (idx > 0) check("b2b_gap", c - last_c, 3);
          last_c = c;
          idx++;
          if (idx < 3) bus.addr_a = b2b_addr[idx];
          else         bus.req_a  = 1'b0;
        end else if (idx > 0) begin
          check("b2b_hold", {24'd0, bus.rdata_a}, {24'd0, b2b_exp[idx-1]});
        end
      end
      check("b2b_count", idx, 3);
    end

    // Protected window
`ifdef ADDR_PROTECT_EN
    run_txn(1'b0, 1'b1, 8'hF4, 8'h11, rd, er, wr, lat);
    check("prot_a_write_cycles", wr, 0);
    check("prot_a_err", {31'd0, er}, 32'd1);
    check("prot_a_mem", {24'd0, mem[8'hF4]}, 32'h22);
    run_txn(1'b0, 1'b0, 8'hF4, 8'h00, rd, er, wr, lat);
    check("prot_a_readback", {24'd0, rd}, 32'h22);
    check("prot_rd_err", {31'd0, er}, 32'd0);
    run_txn(1'b1, 1'b1, 8'hF4, 8'h11, rd, er, wr, lat);
    check("prot_b_write_cycles", wr, 1);
    check("prot_b_err", {31'd0, er}, 32'd0);
    check("prot_b_mem", {24'd0, mem[8'hF4]}, 32'h11);
`else
    run_txn(1'b0, 1'b1, 8'hF4, 8'h11, rd, er, wr, lat);
    check("noprot_a_write_cycles", wr, 1);
    check("noprot_a_err", {31'd0, er}, 32'd0);
    run_txn(1'b1, 1'b0, 8'hF4, 8'h00, rd, er, wr, lat);
    check("noprot_b_readback", {24'd0, rd}, 32'h11);
`endif

    // Reset in the middle of a write's ACCESS cycle
    @(negedge clk);
    bus.we_a = 1'b1; bus.addr_a = 8'h90; bus.wdata_a = 8'h99; bus.req_a = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rm_write_on", {31'd0, bus.mem_write}, 32'd1);
    #1;
    rst = 1'b0;
    bus.req_a = 1'b0; bus.we_a = 1'b0;
    #1;
    check("rm_write_drop", {31'd0, bus.mem_write}, 32'd0);
    check("rm_acks", {30'd0, bus.ack_a, bus.ack_b}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("rm_no_write", {24'd0, mem[8'h90]}, 32'h44);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rm_ctrl", {28'd0, bus.ack_a, bus.ack_b, bus.err, bus.mem_write}, 32'd0);
    check("rm_mem", {16'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
    check("rm_rdata", {16'd0, bus.rdata_a, bus.rdata_b}, 32'd0);

    // Contention: both requests held for four transactions, A first after reset
    begin
      logic order [4];
      int   n_acks = 0;
      int   both   = 0;
      logic exp_b;
      @(negedge clk);
      bus.we_a = 1'b0; bus.addr_a = 8'h80;
      bus.we_b = 1'b0; bus.addr_b = 8'h81;
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      for (int c = 0; c < 40 && n_acks < 4; c++) begin
        @(posedge clk); @(negedge clk);
        if (bus.ack_a && bus.ack_b) both++;
        if (bus.ack_a || bus.ack_b) begin
          order[n_acks] = bus.ack_b;
          n_acks++;
          if (n_acks == 4) begin
            bus.req_a = 1'b0; bus.req_b = 1'b0;
          end
        end
      end
      check("cont_count", n_acks, 4);
      for (int i = 0; i < 4; i++) begin
        exp_b = (i % 2 == 1);
        check("cont_order", {31'd0, order[i]}, {31'd0, exp_b});
      end
      check("cont_both_acks", both, 0);
      check("cont_rdata_a", {24'd0, bus.rdata_a}, 32'h03);
      check("cont_rdata_b", {24'd0, bus.rdata_b}, 32'h77);
    end

    repeat (3) @(negedge clk);
    check("idle_quiet", {30'd0, bus.ack_a, bus.ack_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
